banked_mem: RTL and testbench
=============================

BANKED_MEM -- requirements
Module: banked_mem

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter BANK_AW, default 8, meaning per-bank address width (depth 2**BANK_AW).
REQ-003 The module SHALL have parameter SEL_W, default 2, meaning bank-select width (NUM_BANKS = 2**SEL_W, minimum 1).
REQ-004 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port req_valid  input  1  request present.
REQ-007 The module SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-008 The module SHALL have port wen  input  1  1 = write request, 0 = read request.
REQ-009 The module SHALL have port addr  input  SEL_W+BANK_AW  word address; upper SEL_W bits select the bank, lower BANK_AW bits are the bank index.
REQ-010 The module SHALL have port wdata  input  DATA_W  write data.
REQ-011 The module SHALL have port rsp_valid  output  1  read response valid, one-cycle pulse per accepted read.
REQ-012 The module SHALL have port rdata  output  DATA_W  read response data.
REQ-013 The module SHALL have port init_done  output  1  memory clear complete.

Function
REQ-014 A request SHALL be accepted only on a rising edge where req_valid and req_ready are both 1.
REQ-015 The FSM SHALL have two states, INIT and READY; req_ready SHALL be 1 exactly in READY.
REQ-016 INIT SHALL write zero to index cnt in every bank in parallel, cnt stepping 0 to 2**BANK_AW-1, one index per cycle.
REQ-017 After writing index 2**BANK_AW-1, the FSM SHALL move to READY and set init_done; INIT SHALL last exactly 2**BANK_AW cycles.
REQ-018 READY SHALL have no exit except reset.
REQ-019 An accepted write SHALL update only the entry addr[BANK_AW-1:0] of bank addr[SEL_W+BANK_AW-1:BANK_AW]; all other banks and entries SHALL be unchanged.
REQ-020 An accepted read SHALL assert rsp_valid on the following cycle, with rdata equal to the addressed entry as of the acceptance edge; read latency is 1.
REQ-021 rdata SHALL hold its last response value until the next read response, and SHALL be 0 before the first response.
REQ-022 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Back-to-back reads SHALL give one rsp_valid per read, on consecutive cycles.
REQ-024 Requests with req_valid=1 during INIT SHALL be ignored, and no memory state SHALL change apart from the clear.
REQ-025 No address value SHALL produce X on rdata; every address maps to exactly one bank entry.

Reset
REQ-026 While rst_n=0: state=INIT, cnt=0, init_done=0, req_ready=0, rsp_valid=0, rdata=0.
REQ-027 Reset asserted mid-INIT or mid-READY SHALL restart the clear from index 0 after release.
REQ-028 Reset SHALL discard any pending read response.
REQ-029 Memory contents SHALL be all-zero once init_done rises, regardless of prior contents.

Configuration
REQ-030 With macro BANKED_MEM_PARITY_EN defined, each entry SHALL store an extra even-parity bit (^wdata), written with the data and cleared to 0 in INIT.
REQ-031 With BANKED_MEM_PARITY_EN defined, an output rsp_err (1 bit) SHALL equal parity mismatch of the returned word, qualified by rsp_valid, and reset to 0.
REQ-032 Without BANKED_MEM_PARITY_EN, there SHALL be no parity storage and no rsp_err port.

Verification
REQ-033 Release rst_n with defaults and hold req_valid=1: req_ready=0 for exactly 256 cycles, then init_done=1 and req_ready=1.
REQ-034 After init, read address 0x2A5: rsp_valid=1 one cycle later with rdata=0x00.
REQ-035 Write 0x11 to 0x105, 0x22 to 0x205, 0x33 to 0x305, then read all three: rdata=0x11, 0x22, 0x33 respectively; address 0x005 reads 0x00, proving bank isolation.
REQ-036 Write 0x5A to 0x0FF, then read 0x0FF on the next cycle: rdata=0x5A.
REQ-037 Pulse rst_n low at init cycle 100 after writing data in READY: a new full 256-cycle INIT occurs, and the previously written address then reads 0x00.
REQ-038 With BANKED_MEM_PARITY_EN, write 0x07 and read it back: rsp_err=0; force the stored parity bit to flip and read again: rsp_err=1 with rsp_valid=1.

Source files
------------

// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
//   Word-addressed memory split into NUM_BANKS = 2**SEL_W banks of
//   2**BANK_AW entries each. After reset an INIT phase clears one index in
//   every bank per cycle. The block then enters READY and serves single-cycle
//   requests with a one-cycle read latency.
//
//   Optional feature: define BANKED_MEM_PARITY_EN to store an even-parity bit
//   with each word and report a parity mismatch on rsp_err.
//
// Ports
//   clk        in   clock, all state updates on its rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (high only in READY)
//   wen        in   1 = write, 0 = read
//   addr       in   {bank select [SEL_W], bank index [BANK_AW]}
//   wdata      in   write data
//   rsp_valid  out  one-cycle pulse per accepted read
//   rdata      out  read data, held until the next read response
//   init_done  out  memory clear complete
//   rsp_err    out  (BANKED_MEM_PARITY_EN only) parity mismatch of returned word
// -----------------------------------------------------------------------------
module banked_mem #(
  parameter int DATA_W  = 8,
  parameter int BANK_AW = 8,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     wen,
  input  logic [SEL_W+BANK_AW-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     init_done
`ifdef BANKED_MEM_PARITY_EN
  ,
  output logic                     rsp_err
`endif
);

  localparam int NUM_BANKS = 2 ** SEL_W;
  localparam int DEPTH     = 2 ** BANK_AW;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BANK_AW-1:0] cnt;

  logic [SEL_W-1:0]   bank_sel;
  logic [BANK_AW-1:0] bank_idx;
  logic               accept;
  logic               wr_en;
  logic               rd_en;

  logic [DATA_W-1:0]  mem [NUM_BANKS][DEPTH];
`ifdef BANKED_MEM_PARITY_EN
  logic               par_mem [NUM_BANKS][DEPTH];
`endif

  // Every address value decodes to exactly one bank entry, so no read can
  // select a nonexistent location.
  assign bank_sel = addr[SEL_W+BANK_AW-1:BANK_AW];
  assign bank_idx = addr[BANK_AW-1:0];

  assign req_ready = (state == READY);
  assign init_done = (state == READY);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && wen;
  assign rd_en     = accept && !wen;

  // ---------------------------------------------------------------------------
  // FSM: INIT sweeps cnt over every index, READY is terminal until reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational logic uses blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == {BANK_AW{1'b1}}) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + BANK_AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Clearing is done by the INIT sweep, which runs for a full pass
  // after every reset, so the arrays can be plain RAM.
  // ---------------------------------------------------------------------------
  // NOTE: the memory arrays have no reset branch; a reset would turn them into
  // thousands of flops. Reset restarts the INIT sweep instead.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[b[SEL_W-1:0]][cnt] <= '0;
      end
    end else if (wr_en) begin
      mem[bank_sel][bank_idx] <= wdata;
    end
  end

`ifdef BANKED_MEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        par_mem[b[SEL_W-1:0]][cnt] <= 1'b0;
      end
    end else if (wr_en) begin
      par_mem[bank_sel][bank_idx] <= ^wdata;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read response: registered, so latency is one cycle and a write on the
  // previous edge is already visible. rdata only updates on a read, which
  // makes it hold its last value between responses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
    end else begin
      rsp_valid <= rd_en;
      if (rd_en) begin
        rdata <= mem[bank_sel][bank_idx];
      end
    end
  end

`ifdef BANKED_MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rd_en && ((^mem[bank_sel][bank_idx]) != par_mem[bank_sel][bank_idx]);
    end
  end
`endif

endmodule

// File: tb/tb_banked_mem.sv
// -----------------------------------------------------------------------------
// tb_banked_mem
//   Scoreboard bench for banked_mem (default parameters). The stimulus process
//   keeps a flat 1024-word reference memory; every accepted read pushes the
//   expected word into a queue that a separate negedge monitor pops whenever
//   rsp_valid is seen. Define BANKED_MEM_PARITY_EN to also exercise rsp_err.
// -----------------------------------------------------------------------------
module tb_banked_mem;

  localparam int DATA_W  = 8;
  localparam int BANK_AW = 8;
  localparam int SEL_W   = 2;
  localparam int AW      = SEL_W + BANK_AW;
  localparam int WORDS   = 2 ** AW;
  localparam int DEPTH   = 2 ** BANK_AW;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              wen;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;
  logic              init_done;
`ifdef BANKED_MEM_PARITY_EN
  logic              rsp_err;
`endif

  banked_mem #(
    .DATA_W (DATA_W),
    .BANK_AW(BANK_AW),
    .SEL_W  (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .rsp_valid(rsp_valid),
    .rdata    (rdata),
    .init_done(init_done)
`ifdef BANKED_MEM_PARITY_EN
    ,
    .rsp_err  (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [WORDS];
  logic [DATA_W-1:0] last_rdata;
  bit                tb_ready;
  int                checks;
  int                errors;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per response; between responses rdata must
  // hold the last returned word (0 before the first one after reset).
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", 32'(rdata), 32'(e.data));
`ifdef BANKED_MEM_PARITY_EN
          check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
          last_rdata = e.data;
        end
      end else begin
        check("rdata_hold", 32'(rdata), 32'(last_rdata));
      end
    end
  end

  // One request: inputs set now, accepted on the next rising edge when the
  // bench believes the DUT is in READY. Reads must show rsp_valid right after.
  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                     input logic exp_err = 1'b0);
    exp_t e;
    req_valid = 1'b1;
    wen       = w;
    addr      = a;
    wdata     = d;
    if (tb_ready) begin
      if (w) begin
        model[a] = d;
      end else begin
        e.data = model[a];
        e.err  = exp_err;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check(w ? "wr_no_rsp" : "rd_latency", 32'(rsp_valid), w ? 32'd0 : 32'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset for n cycles, checking reset values, then release. Reset
  // discards pending responses and the clear makes the whole memory zero.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    tb_ready   = 1'b0;
    sb.delete();
    last_rdata = '0;
    for (int i = 0; i < WORDS; i++) model[i] = '0;
    repeat (n) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Counts cycles with req_ready low after release while junk requests are
  // held on the bus; INIT must span exactly DEPTH cycles.
  task automatic init_wait();
    int n;
    n = 0;
    req_valid = 1'b1;
    wen       = 1'b1;
    addr      = AW'(10'h3AB);
    wdata     = 8'hFF;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    req_valid = 1'b0;
    check("init_cycles", 32'(n), 32'(DEPTH));
    check("init_done", 32'(init_done), 32'd1);
    tb_ready = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] pool [8];
    logic [AW-1:0] a;
    checks     = 0;
    errors     = 0;
    tb_ready   = 1'b0;
    last_rdata = '0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    wdata      = '0;

    do_reset(3);
    init_wait();

    // Junk writes held during INIT must not have landed.
    req(1'b0, AW'(10'h3AB), '0);
    // Fresh memory reads zero.
    req(1'b0, AW'(10'h2A5), '0);

    // Bank isolation: same index in banks 1..3, bank 0 untouched.
    req(1'b1, AW'(10'h105), 8'h11);
    req(1'b1, AW'(10'h205), 8'h22);
    req(1'b1, AW'(10'h305), 8'h33);
    req(1'b0, AW'(10'h105), '0);
    req(1'b0, AW'(10'h205), '0);
    req(1'b0, AW'(10'h305), '0);
    req(1'b0, AW'(10'h005), '0);

    // Read on the cycle after a write to the same address.
    req(1'b1, AW'(10'h0FF), 8'h5A);
    req(1'b0, AW'(10'h0FF), '0);
    idle(3);

    // Randomised mix over a small hot set plus fully random addresses.
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom_range(WORDS - 1));
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(3) == 0) ? AW'($urandom_range(WORDS - 1)) : pool[$urandom_range(7)];
      req(1'($urandom_range(1)), a, DATA_W'($urandom));
      if ($urandom_range(7) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset with a read response in flight, then a second reset 100 cycles
    // into the clear; the written word must come back as zero.
    req(1'b1, AW'(10'h1C3), 8'h77);
    req(1'b0, AW'(10'h1C3), '0);
    req(1'b0, AW'(10'h1C3), '0);
    do_reset(2);
    repeat (100) @(posedge clk);
    do_reset(2);
    init_wait();
    req(1'b0, AW'(10'h1C3), '0);
    req(1'b0, AW'(10'h0FF), '0);
    idle(3);

`ifdef BANKED_MEM_PARITY_EN
    req(1'b1, AW'(10'h123), 8'h07);
    req(1'b0, AW'(10'h123), '0, 1'b0);
    idle(2);
    dut.par_mem[1][8'h23] = ~dut.par_mem[1][8'h23];
    req(1'b0, AW'(10'h123), '0, 1'b1);
    idle(2);
`endif

    check("sb_final", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
